eth_phy_10g_rx_link_ctrl: RTL and testbench



---
 rtl/eth_phy_10g_pkg.sv | 30 +++
 rtl/eth_phy_10g_rx_link_ctrl_if.sv | 23 ++
 rtl/eth_phy_10g_rx_ber_mon.sv | 66 ++++++
 rtl/eth_phy_10g_rx_link_ctrl.sv | 130 +++++++++++++
 tb/tb_eth_phy_10g_rx_link_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/eth_phy_10g_pkg.sv
// Shared constants for the 10G PCS receive link controller slice.
package eth_phy_10g_pkg;

  // One-hot link controller states
  localparam logic [4:0] ST_ALIGN_RST = 5'b00001;
  localparam logic [4:0] ST_WAIT_LOCK = 5'b00010;
  localparam logic [4:0] ST_QUALIFY   = 5'b00100;
  localparam logic [4:0] ST_LINK_UP   = 5'b01000;
  localparam logic [4:0] ST_HI_BER    = 5'b10000;

  // Legal 64b/66b sync headers
  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  // BER monitor defaults: 125 us window at 156.25 MHz
  localparam int unsigned DEF_BER_WINDOW = 19531;
  localparam int unsigned DEF_BER_THRESH = 16;

  function automatic logic sh_invalid(input logic [1:0] hdr);
    return (hdr != SH_DATA) && (hdr != SH_CTRL);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/eth_phy_10g_rx_link_ctrl_if.sv
// Aligner-side inputs and MAC-side status of the RX link controller.
interface eth_phy_10g_rx_link_ctrl_if #(
  parameter int unsigned HDR_WIDTH = 2
);
  logic                 i_rx_block_lock;
  logic [HDR_WIDTH-1:0] i_rx_hdr;
  logic                 i_rx_hdr_valid;
  logic                 o_aligner_rst;
  logic                 o_hi_ber;
  logic                 o_link_up;
  logic [5:0]           o_ber_count;
  logic [7:0]           o_retry_cnt;

  modport master (
    output i_rx_block_lock, i_rx_hdr, i_rx_hdr_valid,
    input  o_aligner_rst, o_hi_ber, o_link_up, o_ber_count, o_retry_cnt
  );

  modport slave (
    input  i_rx_block_lock, i_rx_hdr, i_rx_hdr_valid,
    output o_aligner_rst, o_hi_ber, o_link_up, o_ber_count, o_retry_cnt
  );
endinterface

// File: rtl/eth_phy_10g_rx_ber_mon.sv
// Windowed sync-header error counter producing the hi_ber flag.
module eth_phy_10g_rx_ber_mon
  import eth_phy_10g_pkg::*;
#(
  parameter int unsigned HDR_WIDTH  = 2,
  parameter int unsigned BER_WINDOW = DEF_BER_WINDOW,
  parameter int unsigned BER_THRESH = DEF_BER_THRESH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic [HDR_WIDTH-1:0] hdr_i,
  input  logic                 hdr_valid_i,
  output logic                 hi_ber_o,
  output logic [5:0]           ber_cnt_o
);

  localparam int unsigned    WIN_W    = $clog2(BER_WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(BER_WINDOW - 1);
  localparam logic [5:0]     THR      = 6'(BER_THRESH);

  logic [WIN_W-1:0] win_q, win_d;
  logic [5:0]       cnt_q, cnt_d, cnt_inc;
  logic             hi_q, hi_d;
  logic             inv;

  // Next-state: count invalid headers, re-evaluate hi_ber at each window wrap
  always_comb begin
    inv     = hdr_valid_i && sh_invalid(hdr_i);
    cnt_inc = (inv && (cnt_q < THR)) ? cnt_q + 6'd1 : cnt_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    if (clr_i) begin
      win_d = '0;
      cnt_d = '0;
      hi_d  = 1'b0;
    end else if (win_q == WIN_LAST) begin
      // the final-cycle header is folded in so a threshold hit here still sets hi_ber
      win_d = '0;
      cnt_d = '0;
      hi_d  = (cnt_inc == THR);
    end else begin
      win_d = win_q + WIN_W'(1);
      cnt_d = cnt_inc;
      if (cnt_q == THR) hi_d = 1'b1;
    end
  end

  // Monitor state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_q <= '0;
      cnt_q <= '0;
      hi_q  <= 1'b0;
    end else begin
      win_q <= win_d;
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
    end
  end

  assign hi_ber_o  = hi_q;
  assign ber_cnt_o = cnt_q;

endmodule

// File: rtl/eth_phy_10g_rx_link_ctrl.sv
// RX link bring-up FSM: aligner reset/retry, lock qualification, link status.
module eth_phy_10g_rx_link_ctrl
  import eth_phy_10g_pkg::*;
#(
  parameter int unsigned HDR_WIDTH        = 2,
  parameter int unsigned ALIGN_RST_CYCLES = 4,
  parameter int unsigned LOCK_TIMEOUT     = 4096,
  parameter int unsigned LINK_UP_CYCLES   = 1024,
  parameter int unsigned BER_WINDOW       = DEF_BER_WINDOW,
  parameter int unsigned BER_THRESH       = DEF_BER_THRESH
) (
  input logic                       clk,
  input logic                       rst_n,
  eth_phy_10g_rx_link_ctrl_if.slave bus
);

  localparam int unsigned TMR_W = $clog2(max3(LOCK_TIMEOUT, LINK_UP_CYCLES, ALIGN_RST_CYCLES) + 1);
  localparam logic [TMR_W-1:0] T_ARST_LAST = TMR_W'(ALIGN_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] T_LOCK_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] T_UP_LAST   = TMR_W'(LINK_UP_CYCLES - 1);

  logic [4:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [7:0]       retry_q, retry_d;
  logic             arst_q, link_q;
  logic             lock, hi_ber;

  assign lock = bus.i_rx_block_lock;

  eth_phy_10g_rx_ber_mon #(
    .HDR_WIDTH  (HDR_WIDTH),
    .BER_WINDOW (BER_WINDOW),
    .BER_THRESH (BER_THRESH)
  ) u_ber_mon (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (arst_q | ~lock),
    .hdr_i       (bus.i_rx_hdr),
    .hdr_valid_i (bus.i_rx_hdr_valid),
    .hi_ber_o    (hi_ber),
    .ber_cnt_o   (bus.o_ber_count)
  );

  // FSM next-state, shared timer and retry counter
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    case (state_q)
      ST_ALIGN_RST: begin
        if (timer_q == T_ARST_LAST) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (lock) begin
          state_d = ST_QUALIFY;
          timer_d = '0;
        end else if (timer_q == T_LOCK_LAST) begin
          state_d = ST_ALIGN_RST;
          timer_d = '0;
          if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_QUALIFY: begin
        if (!lock) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end else if (hi_ber) begin
          state_d = ST_HI_BER;
          timer_d = '0;
        end else if (timer_q == T_UP_LAST) begin
          state_d = ST_LINK_UP;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_LINK_UP: begin
        if (!lock) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end else if (hi_ber) begin
          state_d = ST_HI_BER;
        end
      end
      ST_HI_BER: begin
        if (!lock) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end else if (!hi_ber) begin
          state_d = ST_QUALIFY;
          timer_d = '0;
        end
      end
      default: begin
        state_d = ST_ALIGN_RST;
        timer_d = '0;
      end
    endcase
  end

  // State registers; aligner reset and link-up are registered from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_ALIGN_RST;
      timer_q <= '0;
      retry_q <= '0;
      arst_q  <= 1'b1;
      link_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      arst_q  <= (state_d == ST_ALIGN_RST);
      link_q  <= (state_d == ST_LINK_UP);
    end
  end

  assign bus.o_aligner_rst = arst_q;
  assign bus.o_link_up     = link_q;
  assign bus.o_hi_ber      = hi_ber;
  assign bus.o_retry_cnt   = retry_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_link_ctrl.sv
// Directed scoreboard bench for the RX link controller.
module tb_eth_phy_10g_rx_link_ctrl;

  typedef struct packed {
    logic       ar;
    logic       lu;
    logic       hb;
    logic [5:0] cnt;
    logic [7:0] rc;
  } obs_t;

  logic  clk = 1'b0;
  logic  rst_n;
  obs_t  sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  string tag     = "init";

  always #5 clk = ~clk;

  eth_phy_10g_rx_link_ctrl_if #(.HDR_WIDTH(2)) bus ();

  eth_phy_10g_rx_link_ctrl #(
    .HDR_WIDTH        (2),
    .ALIGN_RST_CYCLES (4),
    .LOCK_TIMEOUT     (32),
    .LINK_UP_CYCLES   (8),
    .BER_WINDOW       (64),
    .BER_THRESH       (16)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic obs_t mk(input logic ar, input logic lu, input logic hb,
                              input logic [5:0] cnt, input logic [7:0] rc);
    obs_t o;
    o.ar = ar; o.lu = lu; o.hb = hb; o.cnt = cnt; o.rc = rc;
    return o;
  endfunction

  task automatic drive(input logic lock, input logic [1:0] hdr, input logic valid);
    bus.i_rx_block_lock = lock;
    bus.i_rx_hdr        = hdr;
    bus.i_rx_hdr_valid  = valid;
  endtask

  task automatic compare_now();
    obs_t o, e;
    o = {bus.o_aligner_rst, bus.o_link_up, bus.o_hi_ber, bus.o_ber_count, bus.o_retry_cnt};
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s cyc=%0d scoreboard empty, observed=%h", tag, cyc, o);
    end else begin
      e = sb.pop_front();
      assert (o === e) else begin
        n_fail++;
        $error("FAIL %s cyc=%0d observed{ar,lu,hb,cnt,rc}=%h expected=%h", tag, cyc, o, e);
      end
    end
  endtask

  // expectation is queued with the stimulus, checked once the edge has produced it
  task automatic tick(input obs_t e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_now();
  endtask

  task automatic do_reset(input string t);
    tag   = t;
    rst_n = 1'b0;
    drive(1'b0, 2'b01, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    cyc = 0;
    sb.push_back(mk(1'b1, 1'b0, 1'b0, 6'd0, 8'd0));
    compare_now();
    rst_n = 1'b1;
  endtask

  initial begin #500000; $display("FAIL watchdog: bench did not finish"); $fatal(1); end

  initial begin
    int n, s, m, ec;

    // 1: bring-up with lock at cycle 10, clean headers
    do_reset("bringup");
    for (int c = 0; c < 30; c++) begin
      n = c + 1; cyc = n;
      drive(c >= 10, 2'b01, 1'b1);
      tick(mk(n < 4, n >= 19, 1'b0, 6'd0, 8'd0));
    end

    // 2: no lock for 200 cycles, retry every 36 cycles
    do_reset("retry");
    for (int c = 0; c < 200; c++) begin
      n = c + 1; cyc = n;
      drive(1'b0, 2'b01, 1'b1);
      tick(mk((n % 36) < 4, 1'b0, 1'b0, 6'd0, 8'(n / 36)));
    end

    // 3: lock arrives on the timeout cycle, lock wins
    do_reset("lock_vs_timeout");
    for (int c = 0; c < 50; c++) begin
      n = c + 1; cyc = n;
      drive(c >= 35, 2'b01, 1'b1);
      tick(mk(n < 4, n >= 44, 1'b0, 6'd0, 8'd0));
    end

    // 4: 16 invalid headers while up, hi_ber, then recovery after a clean window
    do_reset("hi_ber");
    for (int c = 0; c < 150; c++) begin
      n = c + 1; cyc = n;
      drive(c >= 4, (c >= 20 && c <= 35) ? 2'b11 : 2'b01, 1'b1);
      ec = (n >= 21 && n <= 35) ? n - 20 : (n >= 36 && n <= 67) ? 16 : 0;
      tick(mk(n < 4, (n >= 13 && n <= 37) || n >= 141, n >= 37 && n <= 131, 6'(ec), 8'd0));
    end

    // 5: 15 invalid headers per window for 3 windows, never hi_ber
    do_reset("below_thresh");
    for (int c = 0; c < 210; c++) begin
      logic [1:0] h;
      logic       v;
      n = c + 1; cyc = n;
      h = 2'b01; v = 1'b1;
      if (c >= 4 && c < 196) begin
        s = (c - 4) % 64;
        if (s >= 10 && s <= 17)      h = 2'b11;
        else if (s >= 18 && s <= 24) h = 2'b00;
        else if (s >= 30 && s <= 34) h = 2'b10;
        else if (s >= 40 && s <= 44) begin h = 2'b00; v = 1'b0; end
      end
      drive(c >= 4, h, v);
      m = n - 4;
      if (n < 4 || m / 64 >= 3) ec = 0;
      else begin
        s  = m % 64;
        ec = (s <= 10) ? 0 : (s >= 25) ? 15 : s - 10;
      end
      tick(mk(n < 4, n >= 13, 1'b0, 6'(ec), 8'd0));
    end

    // 6: threshold reached on the final window cycle, hi_ber still asserts
    do_reset("wrap_hit");
    for (int c = 0; c < 145; c++) begin
      n = c + 1; cyc = n;
      drive(c >= 4, (c >= 52 && c <= 67) ? 2'b11 : 2'b01, 1'b1);
      ec = (n >= 53 && n <= 67) ? n - 52 : 0;
      tick(mk(n < 4, (n >= 13 && n <= 68) || n >= 141, n >= 68 && n <= 131, 6'(ec), 8'd0));
    end

    // 7: lock drops as hi_ber would rise; then relock and a 1-cycle reset in LINK_UP
    do_reset("lockdrop_reset");
    for (int c = 0; c < 111; c++) begin
      n = c + 1; cyc = n;
      rst_n = (c == 90) ? 1'b0 : 1'b1;
      drive((c >= 4 && c <= 35) || c >= 75, (c >= 20 && c <= 35) ? 2'b11 : 2'b01, 1'b1);
      ec = (n >= 21 && n <= 35) ? n - 20 : (n == 36) ? 16 : 0;
      tick(mk(n < 4 || (n >= 69 && n <= 72) || (n >= 91 && n <= 94),
              (n >= 13 && n <= 36) || (n >= 84 && n <= 90) || n >= 104,
              1'b0, 6'(ec), (n >= 69 && n <= 90) ? 8'd1 : 8'd0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
